// File: rtl/alu_flag_pkg.sv
// Shared types for the L/V flag unit: microcode flag actions, settle FSM states,
// default IBus bit positions and the action decode helper.
package alu_flag_pkg;

  typedef enum logic [2:0] {
    ACT_NOP = 3'd0,
    ACT_CLL = 3'd1,
    ACT_STL = 3'd2,
    ACT_CPL = 3'd3,
    ACT_CLV = 3'd4,
    ACT_STV = 3'd5,
    ACT_CPV = 3'd6,
    ACT_RSV = 3'd7
  } flag_act_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } settle_st_e;

  localparam int FLAG_L_BIT = 0;
  localparam int FLAG_V_BIT = 1;

  // Applies a microcode action to one flag; is_v selects which flag the caller holds.
  function automatic logic act_apply(input logic cur, input logic [2:0] act, input logic is_v);
    act_apply = cur;
    case (flag_act_e'(act))
      ACT_CLL: if (!is_v) act_apply = 1'b0;
      ACT_STL: if (!is_v) act_apply = 1'b1;
      ACT_CPL: if (!is_v) act_apply = ~cur;
      ACT_CLV: if (is_v)  act_apply = 1'b0;
      ACT_STV: if (is_v)  act_apply = 1'b1;
      ACT_CPV: if (is_v)  act_apply = ~cur;
      default: act_apply = cur;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_settle.sv
// Store-window tracker: waits SETTLE_CYCLES low cycles of nromoe, then issues
// exactly one commit per window; flags windows that close early.
import alu_flag_pkg::*;

module alu_flag_settle #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_nromoe,
  output logic o_commit,
  output logic o_busy,
  output logic o_abort
);

  localparam logic [3:0] LP_N = 4'(SETTLE_CYCLES);

  settle_st_e r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_armed;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;

  // r_armed blocks a window that was already open across reset release.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_nromoe) r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_commit    = 1'b0;
    o_busy      = 1'b0;
    o_abort     = 1'b0;
    if (!i_reset) begin
      case (r_state)
        ST_IDLE: begin
          if (!i_nromoe && r_armed) begin
            o_busy    = 1'b1;
            w_cnt_nxt = 3'd1;
            if (LP_N == 4'd1) begin
              o_commit    = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          o_busy = 1'b1;
          if (i_nromoe) begin
            o_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end else if (w_cnt_inc == LP_N) begin
            o_commit    = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt = w_cnt_inc[2:0];
          end
        end
        ST_HOLD: begin
          if (i_nromoe) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// L (link/carry) and V (overflow) flag registers fed by the ALU ROM, microcode
// actions and IBus loads; per flag: reset > IBus load > ROM commit > action.
import alu_flag_pkg::*;

module alu_flag_unit #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FLAG_L_BIT    = alu_flag_pkg::FLAG_L_BIT,
  parameter int FLAG_V_BIT    = alu_flag_pkg::FLAG_V_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nromoe,
  input  logic        flout_rom,
  input  logic        nsetl_rom,
  input  logic        fvout_rom,
  input  logic        nsetv_rom,
  input  logic [2:0]  action,
  input  logic        flag_we,
  input  logic        flag_re,
  input  logic [15:0] ibus_in,
  output logic [15:0] ibus_out,
  output logic        ibus_oe,
  output logic        fl,
  output logic        fv,
  output logic        busy,
  output logic        abort
);

  logic        r_l, r_v;
  logic        w_l_nxt, w_v_nxt;
  logic        w_commit;
  logic [15:0] w_img;

  alu_flag_settle #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk      (clk),
    .i_reset  (reset),
    .i_nromoe (nromoe),
    .o_commit (w_commit),
    .o_busy   (busy),
    .o_abort  (abort)
  );

  // Lowest priority first, so later assignments override per flag.
  always_comb begin
    w_l_nxt = act_apply(r_l, action, 1'b0);
    w_v_nxt = act_apply(r_v, action, 1'b1);
    if (w_commit && !nsetl_rom) w_l_nxt = flout_rom;
    if (w_commit && !nsetv_rom) w_v_nxt = fvout_rom;
    if (flag_we) begin
      w_l_nxt = ibus_in[FLAG_L_BIT];
      w_v_nxt = ibus_in[FLAG_V_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_l <= w_l_nxt;
      r_v <= w_v_nxt;
    end
  end

  always_comb begin
    w_img             = 16'h0000;
    w_img[FLAG_L_BIT] = r_l;
    w_img[FLAG_V_BIT] = r_v;
  end

  assign ibus_out = w_img;
  assign ibus_oe  = flag_re;
  assign fl       = r_l;
  assign fv       = r_v;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: three instances (SETTLE_CYCLES 1..3) share stimulus; a
// directed vector table plus random cycles are checked against a window-run model.
module tb_alu_flag_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, nromoe, flout_rom, nsetl_rom, fvout_rom, nsetv_rom;
  logic        flag_we, flag_re;
  logic [2:0]  action;
  logic [15:0] ibus_in;

  logic [2:0][15:0] ibus_out;
  logic [2:0]       ibus_oe, fl, fv, busy, abort;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_flag_unit #(.SETTLE_CYCLES(g + 1)) u_dut (
      .clk(clk), .reset(reset), .nromoe(nromoe),
      .flout_rom(flout_rom), .nsetl_rom(nsetl_rom),
      .fvout_rom(fvout_rom), .nsetv_rom(nsetv_rom),
      .action(action), .flag_we(flag_we), .flag_re(flag_re), .ibus_in(ibus_in),
      .ibus_out(ibus_out[g]), .ibus_oe(ibus_oe[g]),
      .fl(fl[g]), .fv(fv[g]), .busy(busy[g]), .abort(abort[g])
    );
  end

  typedef struct {
    logic        rst, nro, flo, nsl, fvo, nsv;
    logic [2:0]  act;
    logic        we, re;
    logic [15:0] bus;
    int          sidx;
    logic        e_busy, e_abort;
    logic [15:0] e_out;
    logic        e_fl, e_fv;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  // Model: per instance, the flags plus the length of the current low run of nromoe.
  logic m_fl[3], m_fv[3];
  int   m_run[3];
  bit   m_armed[3];

  task automatic chk(input string name, input int idx, input logic [15:0] act_v, input logic [15:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, idx, $time, act_v, exp_v);
    end
  endtask

  task automatic row(input logic rst, nro, flo, nsl, fvo, nsv, input logic [2:0] act,
                     input logic we, re, input logic [15:0] bus, input int sidx,
                     input logic eb, ea, input logic [15:0] eo, input logic efl, efv);
    vec_t v;
    v.rst = rst; v.nro = nro; v.flo = flo; v.nsl = nsl; v.fvo = fvo; v.nsv = nsv;
    v.act = act; v.we = we; v.re = re; v.bus = bus; v.sidx = sidx;
    v.e_busy = eb; v.e_abort = ea; v.e_out = eo; v.e_fl = efl; v.e_fv = efv;
    tbl.push_back(v);
  endtask

  task automatic cycle(input vec_t v, input bit use_tbl);
    logic m_commit, m_busy, m_abort, nl, nv;
    logic [15:0] img;
    int s;
    reset = v.rst; nromoe = v.nro; flout_rom = v.flo; nsetl_rom = v.nsl;
    fvout_rom = v.fvo; nsetv_rom = v.nsv; action = v.act;
    flag_we = v.we; flag_re = v.re; ibus_in = v.bus;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s = i + 1;
      if (v.rst) begin
        m_commit = 1'b0; m_busy = 1'b0; m_abort = 1'b0;
      end else begin
        m_commit = m_armed[i] && !v.nro && (m_run[i] + 1 == s);
        m_busy   = m_armed[i] && (m_run[i] < s) && (!v.nro || m_run[i] > 0);
        m_abort  = m_armed[i] && v.nro && (m_run[i] > 0) && (m_run[i] < s);
      end
      img = (16'(m_fl[i]) << 0) | (16'(m_fv[i]) << 1);
      chk("busy", i, 16'(busy[i]), 16'(m_busy));
      chk("abort", i, 16'(abort[i]), 16'(m_abort));
      chk("ibus_out", i, ibus_out[i], img);
      chk("ibus_oe", i, 16'(ibus_oe[i]), 16'(v.re));
      if (v.rst) begin
        nl = 1'b0; nv = 1'b0;
      end else begin
        nl = m_fl[i]; nv = m_fv[i];
        if (v.act == 3'd1) nl = 1'b0;
        if (v.act == 3'd2) nl = 1'b1;
        if (v.act == 3'd3) nl = !m_fl[i];
        if (v.act == 3'd4) nv = 1'b0;
        if (v.act == 3'd5) nv = 1'b1;
        if (v.act == 3'd6) nv = !m_fv[i];
        if (m_commit && !v.nsl) nl = v.flo;
        if (m_commit && !v.nsv) nv = v.fvo;
        if (v.we) begin nl = v.bus[0]; nv = v.bus[1]; end
      end
      m_fl[i] = nl; m_fv[i] = nv;
      if (v.rst) begin
        m_run[i] = 0; m_armed[i] = 1'b0;
      end else if (v.nro) begin
        m_run[i] = 0; m_armed[i] = 1'b1;
      end else if (m_armed[i] && m_run[i] < 8) begin
        m_run[i] = m_run[i] + 1;
      end
    end
    if (use_tbl) begin
      chk("tbl_busy", v.sidx, 16'(busy[v.sidx]), 16'(v.e_busy));
      chk("tbl_abort", v.sidx, 16'(abort[v.sidx]), 16'(v.e_abort));
      chk("tbl_ibus_out", v.sidx, ibus_out[v.sidx], v.e_out);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fl", i, 16'(fl[i]), 16'(m_fl[i]));
      chk("fv", i, 16'(fv[i]), 16'(m_fv[i]));
    end
    if (use_tbl) begin
      chk("tbl_fl", v.sidx, 16'(fl[v.sidx]), 16'(v.e_fl));
      chk("tbl_fv", v.sidx, 16'(fv[v.sidx]), 16'(v.e_fv));
    end
  endtask

  initial begin
    vec_t rv;
    logic nro_r;
    reset = 1'b1; nromoe = 1'b1; flout_rom = 1'b0; nsetl_rom = 1'b1;
    fvout_rom = 1'b0; nsetv_rom = 1'b1; action = 3'd0;
    flag_we = 1'b0; flag_re = 1'b0; ibus_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      m_fl[i] = 1'b0; m_fv[i] = 1'b0; m_run[i] = 0; m_armed[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    //  rst nro flo nsl fvo nsv act we re bus        sidx busy abort out       fl fv
    row(1, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   1, 0, 16'h0000, 1, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   0, 0, 16'h0001, 1, 0);
    row(0, 0, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 2,   1, 0, 16'h0000, 0, 0);
    row(0, 0, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 2,   1, 0, 16'h0000, 0, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 2,   1, 1, 16'h0000, 0, 0);
    row(0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 16'h0000, 2,   1, 0, 16'h0000, 0, 0);
    row(0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 16'h0000, 2,   1, 0, 16'h0000, 0, 0);
    row(0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 16'h0000, 2,   1, 0, 16'h0000, 0, 1);
    row(0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 16'h0000, 2,   0, 0, 16'h0002, 0, 1);
    row(0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 16'h0000, 2,   0, 0, 16'h0002, 0, 1);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 2,   0, 0, 16'h0002, 0, 1);
    row(0, 1, 0, 1, 0, 1, 3'd0, 1, 0, 16'h0001, 0,   0, 0, 16'h0003, 1, 0);
    row(0, 0, 0, 1, 1, 0, 3'd3, 0, 0, 16'h0000, 0,   1, 0, 16'h0001, 0, 1);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   0, 0, 16'h0002, 0, 1);
    row(0, 0, 1, 0, 0, 1, 3'd0, 1, 0, 16'hFFFC, 0,   1, 0, 16'h0002, 0, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 1, 0, 16'h0003, 0,   0, 0, 16'h0000, 1, 1);
    row(0, 1, 0, 1, 0, 1, 3'd0, 1, 1, 16'h0000, 0,   0, 0, 16'h0003, 0, 0);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 1, 16'h0000, 0,   0, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0);
    row(1, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 0);
    row(0, 1, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   0, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0);
    row(0, 0, 1, 0, 1, 0, 3'd0, 0, 0, 16'h0000, 1,   1, 0, 16'h0000, 1, 1);
    row(0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 16'h0000, 1,   0, 0, 16'h0003, 1, 1);

    foreach (tbl[k]) cycle(tbl[k], 1'b1);

    // Random phase: sticky nromoe gives windows of varied length.
    nro_r = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) nro_r = ~nro_r;
      rv.rst  = ($urandom_range(0, 59) == 0);
      rv.nro  = nro_r;
      rv.flo  = 1'($urandom);
      rv.nsl  = 1'($urandom);
      rv.fvo  = 1'($urandom);
      rv.nsv  = 1'($urandom);
      rv.act  = 3'($urandom);
      rv.we   = ($urandom_range(0, 9) == 0);
      rv.re   = 1'($urandom);
      rv.bus  = 16'($urandom);
      rv.sidx = 0;
      rv.e_busy = 1'b0; rv.e_abort = 1'b0; rv.e_out = 16'h0000;
      rv.e_fl = 1'b0; rv.e_fv = 1'b0;
      cycle(rv, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
